// File: rtl/pingpong_pkg.sv
// Shared types and helpers for the ping-pong bank buffer.
//   bank_state_e : ownership of one bank (FREE = writer side, FULL = reader side)
//   ptr_width()  : bit width needed to index n items (at least 1)
package pingpong_pkg;

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_state_e;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
//   clk   : clock, rising edge
//   we    : write enable; wdata stored at waddr
//   re    : read enable; rdata loads mem[raddr] on the edge, otherwise holds
//   rdata : registered read data
module sdp_ram #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned WORDS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pingpong_bank_buffer.sv
// Multi-bank ping-pong buffer. The writer fills its current bank and commits
// it to the reader; the reader drains its current bank and releases it back.
// Both sides walk the banks in the same circular order.
//   clk, rst                       : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data          : write into current write bank
//   wr_commit                      : hand current write bank to the reader
//   wr_ready, wr_bank              : write bank is FREE / its index
//   rd_en/rd_addr                  : read from current read bank (1-cycle latency)
//   rd_release                     : hand current read bank back to the writer
//   rd_ready, rd_bank              : read bank is FULL / its index
//   rd_data, rd_valid              : read result
//   full_count                     : number of FULL banks
//   err                            : one-cycle pulse on any rejected request
module pingpong_bank_buffer
    import pingpong_pkg::*;
#(
    parameter int unsigned BIT_LENGTH = 64,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NUM_BANKS  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic [BIT_LENGTH-1:0]        wr_data,
    input  logic                         wr_commit,
    output logic                         wr_ready,
    output logic [$clog2(NUM_BANKS)-1:0] wr_bank,
    input  logic                         rd_en,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr,
    input  logic                         rd_release,
    output logic                         rd_ready,
    output logic [$clog2(NUM_BANKS)-1:0] rd_bank,
    output logic [BIT_LENGTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic [$clog2(NUM_BANKS):0]   full_count,
    output logic                         err
);

    localparam int unsigned AddrW = ptr_width(DEPTH);
    localparam int unsigned BankW = ptr_width(NUM_BANKS);
    localparam int unsigned CntW  = BankW + 1;
    localparam logic [BankW-1:0] LastBank = BankW'(NUM_BANKS - 1);

    function automatic logic [BankW-1:0] bank_inc(input logic [BankW-1:0] b);
        return (b == LastBank) ? '0 : b + 1'b1;
    endfunction

    bank_state_e      state_q [NUM_BANKS];
    bank_state_e      state_d [NUM_BANKS];
    logic [BankW-1:0] wr_bank_q, wr_bank_d;
    logic [BankW-1:0] rd_bank_q, rd_bank_d;
    logic [CntW-1:0]  full_count_q, full_count_d;
    logic             rd_valid_q;
    logic             err_q, err_d;
    // Masks the RAM output to zero from reset until the first accepted read,
    // since the RAM read register itself has no reset.
    logic             rd_zero_q, rd_zero_d;
    logic [BIT_LENGTH-1:0] ram_rdata;

    logic wr_ok, cm_ok, rd_ok, rl_ok;

    assign wr_ready = (state_q[wr_bank_q] == FREE);
    assign rd_ready = (state_q[rd_bank_q] == FULL);

    // Nothing is accepted in a reset cycle, including the RAM write.
    assign wr_ok = wr_en      & wr_ready & ~rst;
    assign cm_ok = wr_commit  & wr_ready & ~rst;
    assign rd_ok = rd_en      & rd_ready & ~rst;
    assign rl_ok = rd_release & rd_ready & ~rst;

    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        full_count_d = full_count_q;
        rd_zero_d    = rd_zero_q & ~rd_ok;
        err_d        = ~rst & (((wr_en | wr_commit) & ~wr_ready) |
                               ((rd_en | rd_release) & ~rd_ready));

        // Writer and reader never own the same bank, so these never collide.
        if (cm_ok) begin
            state_d[wr_bank_q] = FULL;
            wr_bank_d          = bank_inc(wr_bank_q);
        end
        if (rl_ok) begin
            state_d[rd_bank_q] = FREE;
            rd_bank_d          = bank_inc(rd_bank_q);
        end

        unique case ({cm_ok, rl_ok})
            2'b10:   full_count_d = full_count_q + CntW'(1);
            2'b01:   full_count_d = full_count_q - CntW'(1);
            default: full_count_d = full_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_BANKS); i++) begin
                state_q[i] <= FREE;
            end
            wr_bank_q    <= '0;
            rd_bank_q    <= '0;
            full_count_q <= '0;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            rd_zero_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            full_count_q <= full_count_d;
            rd_valid_q   <= rd_ok;
            err_q        <= err_d;
            rd_zero_q    <= rd_zero_d;
        end
    end

    // Addresses use the pre-advance bank pointers, so a write or read issued
    // together with commit/release targets the bank being handed over.
    sdp_ram #(
        .WIDTH (BIT_LENGTH),
        .WORDS (NUM_BANKS * DEPTH),
        .AW    (BankW + AddrW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr ({wr_bank_q, wr_addr}),
        .wdata (wr_data),
        .re    (rd_ok),
        .raddr ({rd_bank_q, rd_addr}),
        .rdata (ram_rdata)
    );

    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign full_count = full_count_q;
    assign rd_valid   = rd_valid_q;
    assign err        = err_q;
    assign rd_data    = rd_zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_pingpong_bank_buffer.sv
module tb_pingpong_bank_buffer;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // DUT A: 4 banks
    logic        a_wr_en = 0, a_wr_commit = 0, a_rd_en = 0, a_rd_release = 0;
    logic [3:0]  a_wr_addr = 0, a_rd_addr = 0;
    logic [63:0] a_wr_data = 0;
    logic        a_wr_ready, a_rd_ready, a_rd_valid, a_err;
    logic [1:0]  a_wr_bank, a_rd_bank;
    logic [63:0] a_rd_data;
    logic [2:0]  a_full_count;

    // DUT B: 2 banks
    logic        b_wr_en = 0, b_wr_commit = 0, b_rd_en = 0, b_rd_release = 0;
    logic [3:0]  b_wr_addr = 0, b_rd_addr = 0;
    logic [63:0] b_wr_data = 0;
    logic        b_wr_ready, b_rd_ready, b_rd_valid, b_err;
    logic [0:0]  b_wr_bank, b_rd_bank;
    logic [63:0] b_rd_data;
    logic [1:0]  b_full_count;

    pingpong_bank_buffer #(.BIT_LENGTH(64), .DEPTH(16), .NUM_BANKS(4)) dut_a (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .wr_commit(a_wr_commit), .wr_ready(a_wr_ready), .wr_bank(a_wr_bank),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_release(a_rd_release),
        .rd_ready(a_rd_ready), .rd_bank(a_rd_bank), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .full_count(a_full_count), .err(a_err)
    );

    pingpong_bank_buffer #(.BIT_LENGTH(64), .DEPTH(16), .NUM_BANKS(2)) dut_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_commit(b_wr_commit), .wr_ready(b_wr_ready), .wr_bank(b_wr_bank),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_release(b_rd_release),
        .rd_ready(b_rd_ready), .rd_bank(b_rd_bank), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .full_count(b_full_count), .err(b_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest expectation,
    // in the exact cycle it was due.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (a_rd_valid) begin
            if (q_a.size() == 0) begin
                check("a_rd_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = q_a.pop_front();
                check("a_rd_data", a_rd_data, e.data);
                check("a_rd_latency", 64'(cyc), 64'(e.due));
            end
        end
        if (b_rd_valid) begin
            if (q_b.size() == 0) begin
                check("b_rd_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = q_b.pop_front();
                check("b_rd_data", b_rd_data, e.data);
                check("b_rd_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic a_op(input logic we, input logic [3:0] wa, input logic [63:0] wd,
                        input logic cm, input logic re, input logic [3:0] ra,
                        input logic rl, input logic expect_rd, input logic [63:0] exp_rd);
        exp_t e;
        a_wr_en = we; a_wr_addr = wa; a_wr_data = wd; a_wr_commit = cm;
        a_rd_en = re; a_rd_addr = ra; a_rd_release = rl;
        if (expect_rd) begin
            e.data = exp_rd;
            e.due  = cyc + 1;
            q_a.push_back(e);
        end
        tick();
        a_wr_en = 0; a_wr_commit = 0; a_rd_en = 0; a_rd_release = 0;
    endtask

    // Write words 0..15 as base+addr; optionally commit with the last write.
    task automatic a_fill(input logic [63:0] base, input logic commit_last);
        for (int i = 0; i < 16; i++) begin
            a_op(1'b1, 4'(i), base + 64'(i), commit_last && (i == 15),
                 1'b0, 4'd0, 1'b0, 1'b0, 64'd0);
        end
    endtask

    task automatic b_op(input logic we, input logic [3:0] wa, input logic [63:0] wd,
                        input logic cm, input logic re, input logic [3:0] ra,
                        input logic expect_rd, input logic [63:0] exp_rd);
        exp_t e;
        b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_wr_commit = cm;
        b_rd_en = re; b_rd_addr = ra;
        if (expect_rd) begin
            e.data = exp_rd;
            e.due  = cyc + 1;
            q_b.push_back(e);
        end
        tick();
        b_wr_en = 0; b_wr_commit = 0; b_rd_en = 0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_wr_ready", a_wr_ready, 1);
        check("rst_rd_ready", a_rd_ready, 0);
        check("rst_full_count", a_full_count, 0);
        check("rst_rd_valid", a_rd_valid, 0);
        check("rst_rd_data", a_rd_data, 0);
        check("rst_err", a_err, 0);
        check("rst_wr_bank", a_wr_bank, 0);
        check("rst_rd_bank", a_rd_bank, 0);

        // Fill bank 0; last write shares the commit cycle
        a_fill(64'h100, 1'b1);
        check("fill0_rd_ready", a_rd_ready, 1);
        check("fill0_full_count", a_full_count, 1);
        check("fill0_wr_bank", a_wr_bank, 1);
        check("fill0_wr_ready", a_wr_ready, 1);
        a_op(0, 0, 0, 0, 1, 4'd5, 0, 1, 64'h105);
        a_op(0, 0, 0, 0, 1, 4'd15, 0, 1, 64'h10f);
        tick();
        check("idle_rd_valid", a_rd_valid, 0);
        check("idle_rd_hold", a_rd_data, 64'h10f);

        // Fill bank 1, then commit bank 1 + release bank 0 + read addr 3 together
        a_fill(64'h200, 1'b0);
        a_op(0, 0, 0, 1, 1, 4'd3, 1, 1, 64'h103);
        check("swap_full_count", a_full_count, 1);
        check("swap_wr_bank", a_wr_bank, 2);
        check("swap_rd_bank", a_rd_bank, 1);
        a_op(0, 0, 0, 0, 1, 4'd7, 0, 1, 64'h207);

        // Fill every bank
        a_fill(64'h300, 1'b1);
        a_fill(64'h400, 1'b1);
        a_fill(64'h500, 1'b1);
        check("all_full_count", a_full_count, 4);
        check("all_wr_ready", a_wr_ready, 0);
        check("all_wr_bank", a_wr_bank, 1);

        // Rejected write and commit
        a_op(1, 4'd0, 64'hdead, 0, 0, 0, 0, 0, 0);
        check("rej_wr_err", a_err, 1);
        tick();
        check("rej_wr_err_clear", a_err, 0);
        a_op(0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("rej_cm_err", a_err, 1);
        check("rej_cm_full_count", a_full_count, 4);
        check("rej_cm_wr_bank", a_wr_bank, 1);

        // Drain: bank 1 word 0 must still hold 0x200 after the rejected write
        a_op(0, 0, 0, 0, 1, 4'd0, 1, 1, 64'h200);
        check("drain1_full_count", a_full_count, 3);
        check("drain1_rd_bank", a_rd_bank, 2);
        check("drain1_wr_ready", a_wr_ready, 1);
        check("drain1_err", a_err, 0);
        a_op(0, 0, 0, 0, 1, 4'd9, 1, 1, 64'h309);
        a_op(0, 0, 0, 0, 1, 4'd15, 1, 1, 64'h40f);
        a_op(0, 0, 0, 0, 1, 4'd1, 1, 1, 64'h501);
        check("drained_full_count", a_full_count, 0);
        check("drained_rd_ready", a_rd_ready, 0);
        check("drained_rd_bank", a_rd_bank, 1);

        // Rejected read and release
        a_op(0, 0, 0, 0, 1, 4'd4, 0, 0, 0);
        check("rej_rd_err", a_err, 1);
        check("rej_rd_valid", a_rd_valid, 0);
        check("rej_rd_hold", a_rd_data, 64'h501);
        a_op(0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("rej_rl_err", a_err, 1);
        check("rej_rl_rd_bank", a_rd_bank, 1);

        // Reset with two FULL banks
        a_op(1, 4'd0, 64'h600, 1, 0, 0, 0, 0, 0);
        a_op(1, 4'd0, 64'h700, 1, 0, 0, 0, 0, 0);
        check("pre_rst_full_count", a_full_count, 2);
        rst = 1'b1;
        a_op(1, 4'd0, 64'hbad, 1, 1, 0, 1, 0, 0);
        rst = 1'b0;
        check("mid_rst_full_count", a_full_count, 0);
        check("mid_rst_wr_ready", a_wr_ready, 1);
        check("mid_rst_rd_ready", a_rd_ready, 0);
        check("mid_rst_wr_bank", a_wr_bank, 0);
        check("mid_rst_rd_bank", a_rd_bank, 0);
        check("mid_rst_rd_data", a_rd_data, 0);

        // Wrap: six commit/release rounds
        for (int r = 0; r < 6; r++) begin
            check("wrap_wr_bank", a_wr_bank, 64'(r % 4));
            a_op(1, 4'd2, 64'ha000 + 64'(r), 1, 0, 0, 0, 0, 0);
            check("wrap_rd_bank", a_rd_bank, 64'(r % 4));
            a_op(0, 0, 0, 0, 1, 4'd2, 1, 1, 64'ha000 + 64'(r));
        end
        check("wrap_full_count", a_full_count, 0);
        check("wrap_wr_bank_end", a_wr_bank, 2);

        // Two-bank instance
        for (int i = 0; i < 16; i++) begin
            b_op(1, 4'(i), 64'h100 + 64'(i), 0, 0, 0, 0, 0);
        end
        b_op(0, 0, 0, 1, 0, 0, 0, 0);
        check("b_rd_ready", b_rd_ready, 1);
        check("b_full_count", b_full_count, 1);
        check("b_wr_bank", b_wr_bank, 1);
        check("b_wr_ready", b_wr_ready, 1);
        b_op(0, 0, 0, 0, 1, 4'd5, 1, 64'h105);
        b_op(0, 0, 0, 0, 0, 0, 0, 0);
        check("b_rd_bank", b_rd_bank, 0);
        check("b_err", b_err, 0);

        tick();
        tick();
        check("a_scoreboard_drained", 64'(q_a.size()), 0);
        check("b_scoreboard_drained", 64'(q_b.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pingpong_bank_buffer.md
PINGPONG_BANK_BUFFER -- requirements
Module: pingpong_bank_buffer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BIT_LENGTH, 64, data word width.
- DEPTH, 16, words per bank (power of 2, >=2).
- NUM_BANKS, 2, bank count (power of 2, >=2).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- wr_en, in, 1, write strobe.
- wr_addr, in, $clog2(DEPTH), word address within current write bank.
- wr_data, in, BIT_LENGTH, write data.
- wr_commit, in, 1, close current write bank and hand it to the reader.
- wr_ready, out, 1, current write bank is FREE.
- wr_bank, out, $clog2(NUM_BANKS), index of current write bank.
- rd_en, in, 1, read strobe.
- rd_addr, in, $clog2(DEPTH), word address within current read bank.
- rd_release, in, 1, return current read bank to the writer.
- rd_ready, out, 1, current read bank is FULL.
- rd_bank, out, $clog2(NUM_BANKS), index of current read bank.
- rd_data, out, BIT_LENGTH, read data.
- rd_valid, out, 1, rd_data valid this cycle.
- full_count, out, $clog2(NUM_BANKS)+1, number of FULL banks.
- err, out, 1, one-cycle pulse on any rejected request.

Function
REQ-003 Each bank SHALL hold a 1-bit state: FREE (owned by writer) or FULL (owned by reader).
REQ-004 Storage SHALL be NUM_BANKS*DEPTH words addressed {bank, addr}; contents are not reset.
REQ-005 wr_ready SHALL equal state[wr_bank]==FREE; rd_ready SHALL equal state[rd_bank]==FULL (combinational from registered state).
REQ-006 A write with wr_en=1 and wr_ready=1 SHALL store wr_data at {wr_bank, wr_addr} on that edge.
REQ-007 wr_commit=1 with wr_ready=1 SHALL set state[wr_bank]=FULL and advance wr_bank by 1, wrapping NUM_BANKS-1 to 0.
REQ-008 When wr_en and wr_commit are both accepted in one cycle, the write SHALL land in the bank being committed.
REQ-009 rd_en=1 with rd_ready=1 SHALL present the word at {rd_bank, rd_addr} on rd_data with rd_valid=1 exactly one cycle later.
REQ-010 When the read is not accepted, rd_valid SHALL be 0 the next cycle and rd_data SHALL hold its last value.
REQ-011 rd_release=1 with rd_ready=1 SHALL set state[rd_bank]=FREE and advance rd_bank by 1, with wrap.
REQ-012 When rd_en and rd_release are both accepted in one cycle, the read SHALL come from the bank being released; data SHALL still appear next cycle.
REQ-013 An accepted commit and an accepted release in the same cycle SHALL leave full_count unchanged; they always target different banks.
REQ-014 full_count SHALL increment on commit only, decrement on release only, and range 0..NUM_BANKS.
REQ-015 Requests made while not ready SHALL be ignored with no state or memory change. err SHALL pulse high for 1 cycle on any of: wr_en/wr_commit with wr_ready=0, or rd_en/rd_release with rd_ready=0.
REQ-016 Same-cycle write and read to the same physical word cannot occur, because the writer and reader never own the same bank.

Reset
REQ-017 With rst=1 at a clock edge:
- wr_bank=0 and rd_bank=0.
- All banks FREE and full_count=0.
- rd_valid=0, rd_data=0, err=0.
- All requests in that cycle ignored.
REQ-018 Reset mid-operation SHALL discard all bank ownership. The next cycle SHALL show wr_ready=1 and rd_ready=0.

Structure
REQ-019 Package pingpong_pkg SHALL hold the bank_state_e enum (FREE, FULL) and the pointer-width helper function.
REQ-020 Storage SHALL be a sub-module sdp_ram (simple dual-port, 1 write port, 1 registered read port, no reset). Bank state, pointers and counter SHALL stay in the top level.

Verification
REQ-021 Reset then idle -> wr_ready=1, rd_ready=0, full_count=0, rd_valid=0.
REQ-022 NUM_BANKS=2: write addr 0..15 with data 0x100+addr, commit -> rd_ready=1, full_count=1. Read addr 5 -> rd_data=0x105, rd_valid=1 one cycle later.
REQ-023 NUM_BANKS=4: commit 4 banks without release -> full_count=4, wr_ready=0. A 5th write raises err for 1 cycle and memory is unchanged.
REQ-024 In one cycle, commit bank 1 and release bank 0 with read addr 3 -> full_count unchanged, rd_data = bank 0 word 3, both pointers advance.
REQ-025 Wrap: 6 commit/release rounds with NUM_BANKS=4 -> wr_bank and rd_bank sequence 0,1,2,3,0,1, with data integrity per bank.
REQ-026 Assert rst while full_count=2 -> next cycle full_count=0, wr_ready=1, rd_ready=0, wr_bank=0.
